sdf_stage_ctrl: RTL and testbench

Sequencing controller for one radix-2 single-path delay-feedback (SDF) stage of the multimode FFT pipeline. It owns the stage's fixed-depth shift-register delay line and butterfly. It accepts a runtime FFT size, derives the stage delay D, and drives the delay-line enable, tap select, butterfly mode, twiddle address and output valid for each accepted sample. It also drains the delay line at end of stream.

---
 rtl/fft_pkg.sv | 19 +
 rtl/sdf_cnt.sv | 47 ++++
 rtl/sdf_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the multimode FFT pipeline: SDF stage states,
// the default maximum transform size and the per-stage delay helper.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } sdf_state_t;

    localparam int FFT_MAX_LOG2N = 10;

    // Delay of a radix-2 SDF stage: half the sub-transform size seen by that stage.
    function automatic int stage_delay(input int log2n, input int stage);
        return 1 << (log2n - 1 - stage);
    endfunction

endpackage

// File: rtl/sdf_cnt.sv
// Modulo-2D sample counter for an SDF stage. Wraps at 2D-1 and reports
// which half (fill or butterfly) the current count belongs to.
module sdf_cnt
    import fft_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-2:0] d_m1,
    output logic [W-1:0] cnt,
    output logic         half
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load restarts the frame, otherwise advance and wrap at 2D-1.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == {d_m1, 1'b1}) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    // Counts D..2D-1 form the butterfly half.
    assign half = (cnt_q > {1'b0, d_m1});

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF stage. Derives the stage delay
// from a runtime FFT size and drives delay-line enable, tap, butterfly mode,
// twiddle address and output valid. Define SDF_CTRL_FLUSH_EN to drain the
// delay line for D cycles after the last sample; otherwise the stage goes
// straight back to IDLE and relies on upstream zero-stuffing.
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int MAX_LOG2N = FFT_MAX_LOG2N,
    parameter int STAGE     = 0,
    parameter int LW        = $clog2(MAX_LOG2N + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LW-1:0]              cfg_log2n,
    input  logic                       cfg_load,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       sr_en,
    output logic [MAX_LOG2N-2-STAGE:0] tap_sel,
    output logic                       bf_en,
    output logic [MAX_LOG2N-2:0]       tw_addr,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       err_cfg
);

    localparam int TW = MAX_LOG2N - 1 - STAGE;
    localparam int CW = MAX_LOG2N - STAGE;
    localparam int AW = MAX_LOG2N - 1;

    sdf_state_t    state_q, state_d;
    logic [LW-1:0] log2n_q, log2n_d;
    logic          err_cfg_q, err_cfg_d;
    logic [CW-1:0] cnt;
    logic          half;
    logic          accept;
    logic          flushing;
    logic          cfg_legal;
    logic          cnt_load;
    logic          cnt_en;
    logic [TW-1:0] tw_mod;
`ifdef SDF_CTRL_FLUSH_EN
    logic [TW-1:0] fl_q, fl_d;
`endif

    sdf_cnt #(
        .W(CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .load (cnt_load),
        .d_m1 (tap_sel),
        .cnt  (cnt),
        .half (half)
    );

    // Handshake, datapath controls and twiddle address, all same-cycle.
    always_comb begin
        tap_sel   = TW'(stage_delay(int'(log2n_q), STAGE) - 1);
        cfg_legal = (int'(cfg_log2n) > STAGE) && (int'(cfg_log2n) <= MAX_LOG2N);
        in_ready  = (state_q == FILL) || (state_q == RUN);
        accept    = in_valid & in_ready;
        flushing  = (state_q == FLUSH);
        busy      = (state_q != IDLE);
        sr_en     = accept | flushing;
        out_valid = (accept && (state_q == RUN)) | flushing;
        bf_en     = in_ready & half;
        tw_mod    = cnt[TW-1:0] & tap_sel;
        tw_addr   = (bf_en || (state_q == IDLE)) ? '0 : (AW'(tw_mod) << STAGE);
        cnt_en    = accept | flushing;
        cnt_load  = (state_q == IDLE) & cfg_load & cfg_legal;
    end

    // Next-state logic: configuration in IDLE, fill/run sequencing, end of stream.
    always_comb begin
        state_d   = state_q;
        log2n_d   = log2n_q;
        err_cfg_d = err_cfg_q;
`ifdef SDF_CTRL_FLUSH_EN
        fl_d      = fl_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    if (cfg_legal) begin
                        log2n_d   = cfg_log2n;
                        err_cfg_d = 1'b0;
                        state_d   = FILL;
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            FILL, RUN: begin
                if (accept) begin
                    if (in_last) begin
`ifdef SDF_CTRL_FLUSH_EN
                        state_d = FLUSH;
                        fl_d    = '0;
`else
                        state_d = IDLE;
`endif
                    end else if ((state_q == FILL) && (cnt == {1'b0, tap_sel})) begin
                        state_d = RUN;
                    end
                end
            end
            FLUSH: begin
`ifdef SDF_CTRL_FLUSH_EN
                if (fl_q == tap_sel) begin
                    state_d = IDLE;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset abandons any frame and selects the largest size.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            log2n_q   <= LW'(MAX_LOG2N);
            err_cfg_q <= 1'b0;
`ifdef SDF_CTRL_FLUSH_EN
            fl_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            log2n_q   <= log2n_d;
            err_cfg_q <= err_cfg_d;
`ifdef SDF_CTRL_FLUSH_EN
            fl_q      <= fl_d;
`endif
        end
    end

    assign err_cfg = err_cfg_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed testbench for sdf_stage_ctrl with MAX_LOG2N = 4, STAGE = 0.
// Honours SDF_CTRL_FLUSH_EN in the same way as the design.
module tb_sdf_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cfg_log2n = '0;
    logic       cfg_load = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       sr_en;
    logic [2:0] tap_sel;
    logic       bf_en;
    logic [2:0] tw_addr;
    logic       out_valid;
    logic       busy;
    logic       err_cfg;

    int n_chk  = 0;
    int n_pass = 0;

    sdf_stage_ctrl #(
        .MAX_LOG2N(4),
        .STAGE    (0),
        .LW       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_log2n(cfg_log2n),
        .cfg_load (cfg_load),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .sr_en    (sr_en),
        .tap_sel  (tap_sel),
        .bf_en    (bf_en),
        .tw_addr  (tw_addr),
        .out_valid(out_valid),
        .busy     (busy),
        .err_cfg  (err_cfg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, settle, then the caller checks.
    task automatic cycle(input logic v, input logic last, input logic ld, input int cfg);
        @(negedge clk);
        in_valid  = v;
        in_last   = last;
        cfg_load  = ld;
        cfg_log2n = 3'(cfg);
        #1;
    endtask

    task automatic load_cfg(input int cfg);
        cycle(1'b0, 1'b0, 1'b1, cfg);
    endtask

    // Stream n samples with delay d; optional last and stall (with ignored reload).
    task automatic run_samples(input int n, input int d, input int last_at, input int stall_at);
        int bf;
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                cycle(1'b0, 1'b0, 1'b1, 1);
                check_eq($sformatf("stall_sr_en k%0d", k), int'(sr_en), 0);
                check_eq($sformatf("stall_out_valid k%0d", k), int'(out_valid), 0);
                check_eq($sformatf("stall_in_ready k%0d", k), int'(in_ready), 1);
            end
            cycle(1'b1, (k == last_at), 1'b0, 0);
            bf = ((k % (2 * d)) >= d) ? 1 : 0;
            $display("sample d=%0d k=%0d bf_en=%0d tw=%0d out_valid=%0d", d, k, bf_en, tw_addr, out_valid);
            check_eq($sformatf("in_ready k%0d", k), int'(in_ready), 1);
            check_eq($sformatf("sr_en k%0d", k), int'(sr_en), 1);
            check_eq($sformatf("out_valid k%0d", k), int'(out_valid), (k >= d) ? 1 : 0);
            check_eq($sformatf("bf_en k%0d", k), int'(bf_en), bf);
            check_eq($sformatf("tw_addr k%0d", k), int'(tw_addr), (bf == 1) ? 0 : (k % d));
            check_eq($sformatf("tap_sel k%0d", k), int'(tap_sel), d - 1);
        end
    endtask

    // End of stream after n accepted samples with delay d.
    task automatic end_stream(input int n, input int d);
`ifdef SDF_CTRL_FLUSH_EN
        int c0;
        c0 = n % (2 * d);
        for (int i = 0; i < d; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 0);
            $display("flush d=%0d i=%0d sr_en=%0d out_valid=%0d tw=%0d", d, i, sr_en, out_valid, tw_addr);
            check_eq($sformatf("flush_in_ready i%0d", i), int'(in_ready), 0);
            check_eq($sformatf("flush_sr_en i%0d", i), int'(sr_en), 1);
            check_eq($sformatf("flush_out_valid i%0d", i), int'(out_valid), 1);
            check_eq($sformatf("flush_bf_en i%0d", i), int'(bf_en), 0);
            check_eq($sformatf("flush_tw i%0d", i), int'(tw_addr), (c0 + i) % d);
            check_eq($sformatf("flush_busy i%0d", i), int'(busy), 1);
        end
`endif
        cycle(1'b1, 1'b0, 1'b0, 0);
        check_eq("end_busy", int'(busy), 0);
        check_eq("end_in_ready", int'(in_ready), 0);
        check_eq("end_sr_en", int'(sr_en), 0);
        check_eq("end_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        // Reset state.
        #12;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_sr_en", int'(sr_en), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_bf_en", int'(bf_en), 0);
        check_eq("rst_tw_addr", int'(tw_addr), 0);
        check_eq("rst_err_cfg", int'(err_cfg), 0);
        check_eq("rst_tap_sel", int'(tap_sel), 7);
        @(negedge clk);
        rst = 1'b0;

        // Illegal loads, then a legal one clears the error.
        load_cfg(0);
        cycle(1'b0, 1'b0, 1'b0, 0);
        $display("load cfg=0 err_cfg=%0d busy=%0d", err_cfg, busy);
        check_eq("ill0_err", int'(err_cfg), 1);
        check_eq("ill0_busy", int'(busy), 0);
        load_cfg(5);
        cycle(1'b0, 1'b0, 1'b0, 0);
        $display("load cfg=5 err_cfg=%0d busy=%0d", err_cfg, busy);
        check_eq("ill5_err", int'(err_cfg), 1);
        check_eq("ill5_busy", int'(busy), 0);
        load_cfg(4);
        cycle(1'b0, 1'b0, 1'b0, 0);
        $display("load cfg=4 err_cfg=%0d tap_sel=%0d", err_cfg, tap_sel);
        check_eq("leg4_err", int'(err_cfg), 0);
        check_eq("leg4_busy", int'(busy), 1);
        check_eq("leg4_tap", int'(tap_sel), 7);
        check_eq("leg4_in_ready", int'(in_ready), 1);
        // Single-sample frame at D = 8, last in FILL.
        run_samples(1, 8, 0, -1);
        end_stream(1, 8);

        // D = 4: 16 samples with a stall and an ignored reload, then one last sample.
        load_cfg(3);
        run_samples(17, 4, 16, 5);
        end_stream(17, 4);

        // D = 4: last at sample 11.
        load_cfg(3);
        run_samples(12, 4, 11, -1);
        end_stream(12, 4);

        // Minimum delay D = 1.
        load_cfg(1);
        run_samples(4, 1, 3, -1);
        end_stream(4, 1);

        // Reset mid-RUN.
        load_cfg(3);
        run_samples(6, 4, -1, -1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset mid-run busy=%0d tap_sel=%0d", busy, tap_sel);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_in_ready", int'(in_ready), 0);
        check_eq("mid_rst_out_valid", int'(out_valid), 0);
        check_eq("mid_rst_sr_en", int'(sr_en), 0);
        check_eq("mid_rst_tap", int'(tap_sel), 7);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 0);
        check_eq("post_rst_busy", int'(busy), 0);
        check_eq("post_rst_sr_en", int'(sr_en), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
